// File: rtl/pipe_hold_ctrl.sv
// Pipeline sequencer: drives per-stage hold/flush fields, redirect strobe and debug halt.
// Optional statistics counters are enabled by defining PIPE_HOLD_CTRL_STAT_EN.
module pipe_hold_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jump_req_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              ex_hold_i,
  input  logic              bus_hold_i,
  input  logic              dbg_halt_i,
  input  logic              dbg_resume_i,
  output logic              jump_flag_o,
  output logic [ADDR_W-1:0] jump_addr_o,
  output logic [7:0]        hold_o,
  output logic              halted_o,
  output logic [2:0]        state_o
`ifdef PIPE_HOLD_CTRL_STAT_EN
  ,
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       flush_cnt_o,
  output logic [31:0]       halt_cnt_o
`endif
);

  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] F_RUN   = 2'b00;
  localparam logic [1:0] F_HOLD  = 2'b01;
  localparam logic [1:0] F_FLUSH = 2'b10;

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_FLUSH  = 3'd1,
    ST_STALL  = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HALTED = 3'd4
  } state_e;

  state_e             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx, cnt_dec;
  logic               pend_jump, pend_jump_nx;
  logic [ADDR_W-1:0]  pend_addr, pend_addr_nx;
  logic               pend_halt, pend_halt_nx;
  logic               halt_block, halt_block_nx;
  logic               jump_flag_nx;
  logic [ADDR_W-1:0]  jump_addr_nx;
  logic [1:0]         pc_f, if_id_f, id_ex_f, ex_mem_f;
  logic               stall_any;
  logic               halt_new;
  logic               can_jump;

  assign stall_any = bus_hold_i | ex_hold_i;
  // A halt still held across a resume must drop before it can halt again.
  assign halt_new  = dbg_halt_i & ~halt_block;
  assign can_jump  = ~jump_flag_o;
  assign cnt_dec   = (cnt == '0) ? '0 : cnt - CNT_W'(1);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RUN;
    end else begin
      state <= state_nx;
    end
  end

  // Counter, pending requests and registered redirect outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      pend_jump   <= 1'b0;
      pend_addr   <= '0;
      pend_halt   <= 1'b0;
      halt_block  <= 1'b0;
      jump_flag_o <= 1'b0;
      jump_addr_o <= '0;
    end else begin
      cnt         <= cnt_nx;
      pend_jump   <= pend_jump_nx;
      pend_addr   <= pend_addr_nx;
      pend_halt   <= pend_halt_nx;
      halt_block  <= halt_block_nx;
      jump_flag_o <= jump_flag_nx;
      jump_addr_o <= jump_addr_nx;
    end
  end

  // Next-state and next-datapath logic
  always_comb begin
    state_nx      = state;
    cnt_nx        = cnt;
    pend_jump_nx  = pend_jump;
    pend_addr_nx  = pend_addr;
    pend_halt_nx  = pend_halt;
    halt_block_nx = halt_block & dbg_halt_i;
    jump_flag_nx  = 1'b0;
    jump_addr_nx  = jump_addr_o;
    case (state)
      ST_RUN: begin
        if (stall_any) begin
          state_nx = ST_STALL;
          if (jump_req_i) begin
            pend_jump_nx = 1'b1;
            pend_addr_nx = jump_addr_i;
          end
          if (halt_new) pend_halt_nx = 1'b1;
        end else if (jump_req_i && can_jump) begin
          jump_flag_nx = 1'b1;
          jump_addr_nx = jump_addr_i;
          state_nx     = ST_FLUSH;
          cnt_nx       = CNT_W'(FLUSH_CYCLES);
        end else if (halt_new || pend_halt) begin
          state_nx     = ST_DRAIN;
          cnt_nx       = CNT_W'(DRAIN_CYCLES);
          pend_halt_nx = 1'b0;
        end
      end
      ST_STALL: begin
        if (halt_new) pend_halt_nx = 1'b1;
        if (stall_any) begin
          // Keep the oldest redirect; later ones are on its wrong path.
          if (jump_req_i && !pend_jump) begin
            pend_jump_nx = 1'b1;
            pend_addr_nx = jump_addr_i;
          end
        end else if (pend_jump || jump_req_i) begin
          jump_flag_nx = 1'b1;
          jump_addr_nx = pend_jump ? pend_addr : jump_addr_i;
          pend_jump_nx = 1'b0;
          state_nx     = ST_FLUSH;
          cnt_nx       = CNT_W'(FLUSH_CYCLES);
        end else begin
          state_nx = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (halt_new) pend_halt_nx = 1'b1;
        if (!bus_hold_i) begin
          cnt_nx = cnt_dec;
          if (cnt_dec == '0) state_nx = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (jump_req_i && can_jump) begin
          jump_flag_nx = 1'b1;
          jump_addr_nx = jump_addr_i;
          cnt_nx       = CNT_W'(DRAIN_CYCLES);
        end else if (!bus_hold_i) begin
          cnt_nx = cnt_dec;
          if (cnt_dec == '0) state_nx = ST_HALTED;
        end
      end
      ST_HALTED: begin
        if (dbg_resume_i) begin
          state_nx      = ST_RUN;
          halt_block_nx = dbg_halt_i;
        end
      end
      default: state_nx = ST_RUN;
    endcase
  end

  // Per-stage field decode; a busy data bus freezes every stage
  always_comb begin
    pc_f     = F_RUN;
    if_id_f  = F_RUN;
    id_ex_f  = F_RUN;
    ex_mem_f = F_RUN;
    halted_o = 1'b0;
    case (state)
      ST_RUN, ST_STALL: begin
        if (bus_hold_i) begin
          pc_f     = F_HOLD;
          if_id_f  = F_HOLD;
          id_ex_f  = F_HOLD;
          ex_mem_f = F_HOLD;
        end else if (ex_hold_i) begin
          pc_f     = F_HOLD;
          if_id_f  = F_HOLD;
          id_ex_f  = F_HOLD;
          ex_mem_f = F_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (bus_hold_i) begin
          pc_f     = F_HOLD;
          if_id_f  = F_HOLD;
          id_ex_f  = F_HOLD;
          ex_mem_f = F_HOLD;
        end else begin
          if_id_f  = F_FLUSH;
          id_ex_f  = F_FLUSH;
        end
      end
      ST_DRAIN: begin
        if (bus_hold_i) begin
          pc_f     = F_HOLD;
          if_id_f  = F_HOLD;
          id_ex_f  = F_HOLD;
          ex_mem_f = F_HOLD;
        end else begin
          pc_f     = F_HOLD;
          if_id_f  = F_FLUSH;
        end
      end
      ST_HALTED: begin
        pc_f     = F_HOLD;
        if_id_f  = F_HOLD;
        id_ex_f  = F_HOLD;
        ex_mem_f = F_HOLD;
        halted_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign hold_o  = {ex_mem_f, id_ex_f, if_id_f, pc_f};
  assign state_o = state;

`ifdef PIPE_HOLD_CTRL_STAT_EN
  logic any_hold;
  assign any_hold = (pc_f == F_HOLD) || (if_id_f == F_HOLD) ||
                    (id_ex_f == F_HOLD) || (ex_mem_f == F_HOLD);

  // Free-running event counters, wrapping at 2^32
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
      halt_cnt_o  <= '0;
    end else begin
      if (any_hold)     stall_cnt_o <= stall_cnt_o + 32'd1;
      if (jump_flag_nx) flush_cnt_o <= flush_cnt_o + 32'd1;
      if ((state != ST_HALTED) && (state_nx == ST_HALTED))
        halt_cnt_o <= halt_cnt_o + 32'd1;
    end
  end
`endif

endmodule
